// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract arbiter slice.
// FSM state encoding and requester ids live here.
package addsub_pkg;

  localparam int ADDSUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic ID0 = 1'b0;
  localparam logic ID1 = 1'b1;

endpackage

// File: rtl/adder_subtractor.sv
// Combinational two's-complement adder/subtractor.
// Carry-out is dropped; ovfl reports signed overflow.
module adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] result_o,
  output logic             ovfl_o
);

  logic sa;
  logic sb;
  logic sr;

  assign sa = a_i[WIDTH-1];
  assign sb = b_i[WIDTH-1];
  assign sr = result_o[WIDTH-1];

  // add or subtract, then flag a sign flip not explained by operands
  always_comb begin
    result_o = mode_i ? (a_i - b_i) : (a_i + b_i);
    if (mode_i) ovfl_o = (sa != sb) && (sr != sa);
    else        ovfl_o = (sa == sb) && (sr != sa);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for one shared add/sub unit.
// IDLE grants and captures, EXEC computes, RESP holds until accepted.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             mode0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             mode1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             busy
);

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   win;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             mode_q, mode_d;
  logic             id_q, id_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovfl_q, ovfl_d;
  logic             oid_q, oid_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovfl;

  adder_subtractor #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i     (opa_q),
    .b_i     (opb_q),
    .mode_i  (mode_q),
    .result_o(alu_res),
    .ovfl_o  (alu_ovfl)
  );

  // pick the winner: lone requester, else the one not granted last
  always_comb begin
    win = ID0;
    unique case (1'b1)
      req0 & ~req1: win = ID0;
      req1 & ~req0: win = ID1;
      default:      win = (last_q == ID0) ? ID1 : ID0;
    endcase
  end

  // next-state and register updates for the FSM datapath
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    mode_d  = mode_q;
    id_d    = id_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    res_d   = res_q;
    ovfl_d  = ovfl_q;
    oid_d   = oid_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          opa_d   = win ? a1 : a0;
          opb_d   = win ? b1 : b0;
          mode_d  = win ? mode1 : mode0;
          id_d    = win;
          last_d  = win;
          gnt0_d  = (win == ID0);
          gnt1_d  = (win == ID1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        ovfl_d  = alu_ovfl;
        oid_d   = id_q;
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers with async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID1;
      opa_q   <= '0;
      opb_q   <= '0;
      mode_q  <= 1'b0;
      id_q    <= ID0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      res_q   <= '0;
      ovfl_q  <= 1'b0;
      oid_q   <= ID0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      res_q   <= res_d;
      ovfl_q  <= ovfl_d;
      oid_q   <= oid_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign out_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign result    = res_q;
  assign ovfl      = ovfl_q;
  assign out_id    = oid_q;

endmodule
